// File: rtl/decode_arbiter_if.sv
// decode_arbiter_if: bundle between the requesting units, the arbiter and the
// shared decode FSM. The master side drives requests and FSM status; the
// slave side (the arbiter) returns grants, completions and FSM load strobes.
interface decode_arbiter_if #(
  parameter int NREQ = 4,
  parameter int SW = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*SW-1:0] req_state;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [SW-1:0]      result_state;
  logic               timeout_err;
  logic               fsm_load;
  logic [SW-1:0]      fsm_load_state;
  logic [SW-1:0]      fsm_state;
  logic               fsm_done;

  modport master (
    output req, req_state, fsm_state, fsm_done,
    input  gnt, done, result_state, timeout_err, fsm_load, fsm_load_state
  );

  modport slave (
    input  req, req_state, fsm_state, fsm_done,
    output gnt, done, result_state, timeout_err, fsm_load, fsm_load_state
  );
endinterface

// File: rtl/decode_arbiter.sv
// decode_arbiter: shares one decode FSM among NREQ requesters. A round-robin
// winner's entry state is loaded into the FSM, the FSM is watched until it
// reports a terminal state or TIMEOUT RUN cycles elapse, and the final state is
// returned to the winner with a one-cycle done pulse.
// Optional build macro DECODE_ARB_ABORT_EN: withdrawing req during RUN aborts
// the transaction and reloads the FSM with IDLE_STATE.
module decode_arbiter #(
  parameter int NREQ = 4,
  parameter int SW = 4,
  parameter int TIMEOUT = 15,
  parameter logic [SW-1:0] IDLE_STATE = SW'(4'hc)
) (
  input logic clk,
  input logic rst_n,
  decode_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   rr_ptr, idx, win_idx;
  logic            win_found;
  logic [SW-1:0]   win_state, entry, result;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] done_q;
  logic            terr_q, abort_q;
  logic            finish, timed_out, abort;
  logic [NREQ-1:0] idx_onehot;

  assign idx_onehot = NREQ'(1) << idx;

  // Pick the first requester at or after rr_ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    int j;
    j = 0;
    win_found = 1'b0;
    win_idx = '0;
    win_state = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win_idx = IW'(j);
        win_state = bus.req_state[j*SW +: SW];
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, plus how a RUN phase ends: abort beats fsm_done beats timeout.
  always_comb begin
    state_next = state;
    finish = 1'b0;
    timed_out = 1'b0;
    abort = 1'b0;
    case (state)
      S_IDLE: if (win_found) state_next = S_LOAD;
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
`ifdef DECODE_ARB_ABORT_EN
        abort = ~bus.req[idx];
`endif
        if (!abort) begin
          if (bus.fsm_done) begin
            finish = 1'b1;
          end else if (cnt == CNT_LAST) begin
            finish = 1'b1;
            timed_out = 1'b1;
          end
        end
        if (abort || finish) state_next = S_RELEASE;
      end
      S_RELEASE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Winner capture, RUN counter, completion reporting and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      idx     <= '0;
      entry   <= '0;
      cnt     <= '0;
      result  <= '0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q <= '0;
      terr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            idx   <= win_idx;
            entry <= win_state;
          end
        end
        S_LOAD: cnt <= '0;
        S_RUN: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (finish) begin
            result <= bus.fsm_state;
            done_q <= idx_onehot;
            terr_q <= timed_out;
          end
          abort_q <= abort;
        end
        S_RELEASE: begin
          rr_ptr  <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Grant and FSM load strobes decoded from the controller state.
  always_comb begin
    bus.gnt = '0;
    bus.fsm_load = 1'b0;
    bus.fsm_load_state = '0;
    case (state)
      S_LOAD: begin
        bus.gnt = idx_onehot;
        bus.fsm_load = 1'b1;
        bus.fsm_load_state = entry;
      end
      S_RUN: bus.gnt = idx_onehot;
      S_RELEASE: begin
        if (abort_q) begin
          bus.fsm_load = 1'b1;
          bus.fsm_load_state = IDLE_STATE;
        end
      end
      default: ;
    endcase
  end

  assign bus.done = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.result_state = result;
endmodule

// File: tb/tb_decode_arbiter.sv
// tb_decode_arbiter: table vectors, hand-written corner sequences and random
// transactions checked against a transaction-level round-robin model.
module tb_decode_arbiter;
  localparam int NREQ = 4;
  localparam int SW = 4;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] rs;
    int          done_at;
    logic [3:0]  key;
    int          e_idx;
    logic        e_to;
    logic [3:0]  e_load;
    logic [3:0]  e_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mptr = 0;
  vec_t tbl[6];

  decode_arbiter_if #(.NREQ(NREQ), .SW(SW)) bus();

  decode_arbiter #(
    .NREQ(NREQ), .SW(SW), .TIMEOUT(TIMEOUT), .IDLE_STATE(4'hc)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first set request bit at or after ptr, with wrap.
  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One full transaction from IDLE; fsm_state during RUN cycle k is key^k.
  task automatic txn(input string nm, input logic [3:0] r, input logic [15:0] rs,
                     input int done_at, input int drop_at, input logic [3:0] key,
                     input int e_idx, input logic e_to, input logic [3:0] e_load,
                     input logic [3:0] e_res, output int load_cyc);
    int lat, k, e_runs;
    logic [3:0] e_gnt;
    bit fin;
    e_gnt = 4'(1 << e_idx);
    e_runs = (done_at >= 1 && done_at <= TIMEOUT) ? done_at : TIMEOUT;
    bus.req = r;
    bus.req_state = rs;
    bus.fsm_done = 1'b0;
    bus.fsm_state = '0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.fsm_load && lat < 6);
    load_cyc = cyc;
    bus.req_state = ~rs;
    chk({nm, "/load_latency"}, lat, 1);
    chk({nm, "/gnt_load"}, bus.gnt, e_gnt);
    chk({nm, "/load_state"}, bus.fsm_load_state, e_load);
    k = 0;
    fin = 1'b0;
    while (!fin && k < 40) begin
      step();
      if (bus.done != 0 || bus.gnt == 0) begin
        fin = 1'b1;
      end else begin
        k++;
        chk({nm, "/gnt_run"}, bus.gnt, e_gnt);
        chk({nm, "/load_run"}, bus.fsm_load, 1'b0);
        bus.fsm_state = key ^ 4'(k);
        bus.fsm_done = (k == done_at);
        if (k == drop_at) bus.req = '0;
      end
    end
    chk({nm, "/run_cycles"}, k, e_runs);
    chk({nm, "/done"}, bus.done, e_gnt);
    chk({nm, "/timeout_err"}, bus.timeout_err, e_to);
    chk({nm, "/result"}, bus.result_state, e_res);
    chk({nm, "/gnt_release"}, bus.gnt, 4'b0);
    chk({nm, "/load_release"}, bus.fsm_load, 1'b0);
    bus.fsm_done = 1'b0;
    step();
    chk({nm, "/done_idle"}, bus.done, 4'b0);
    chk({nm, "/terr_idle"}, bus.timeout_err, 1'b0);
    chk({nm, "/result_hold"}, bus.result_state, e_res);
    mptr = (e_idx + 1) % NREQ;
  endtask

  initial begin
    int lc, prev_lc, e_idx, da, dr, runs;
    logic [3:0] r, key, e_res, prev_res;
    logic [15:0] rs;
    logic e_to;
    int rr_exp[5];
    logic [3:0] rr_load[5];

    tbl[0] = '{4'b0010, 16'h5eb3, 3,  4'hf, 1, 1'b0, 4'hb, 4'hc};
    tbl[1] = '{4'b1001, 16'h5eb3, 1,  4'h3, 3, 1'b0, 4'h5, 4'h2};
    tbl[2] = '{4'b0001, 16'h0009, 0,  4'h5, 0, 1'b1, 4'h9, 4'ha};
    tbl[3] = '{4'b0101, 16'h5eb3, 15, 4'h7, 2, 1'b0, 4'he, 4'h8};
    tbl[4] = '{4'b0110, 16'h5eb3, 14, 4'h0, 1, 1'b0, 4'hb, 4'he};
    tbl[5] = '{4'b1000, 16'h5eb3, 2,  4'h9, 3, 1'b0, 4'h5, 4'hb};
    rr_exp = '{0, 1, 2, 3, 0};
    rr_load = '{4'h3, 4'hb, 4'he, 4'h5, 4'h3};

    bus.req = 4'hf;
    bus.req_state = 16'h5eb3;
    bus.fsm_state = '0;
    bus.fsm_done = 1'b0;
    repeat (3) step();
    chk("reset/gnt", bus.gnt, 4'b0);
    chk("reset/done", bus.done, 4'b0);
    chk("reset/fsm_load", bus.fsm_load, 1'b0);
    chk("reset/load_state", bus.fsm_load_state, 4'h0);
    chk("reset/result", bus.result_state, 4'h0);
    chk("reset/timeout_err", bus.timeout_err, 1'b0);
    bus.req = '0;
    rst_n = 1'b1;
    mptr = 0;

    for (int i = 0; i < 6; i++)
      txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].rs, tbl[i].done_at, 0,
          tbl[i].key, tbl[i].e_idx, tbl[i].e_to, tbl[i].e_load, tbl[i].e_res, lc);

    prev_lc = 0;
    for (int i = 0; i < 5; i++) begin
      txn($sformatf("rr%0d", i), 4'hf, 16'h5eb3, 1, 0, 4'(i), rr_exp[i], 1'b0,
          rr_load[i], 4'(i) ^ 4'h1, lc);
      if (i > 0) chk($sformatf("rr%0d/load_spacing", i), lc - prev_lc, 4);
      prev_lc = lc;
    end

    txn("pre_rst", 4'b0100, 16'h5eb3, 2, 0, 4'h4, pick(4'b0100, mptr), 1'b0,
        4'he, 4'h6, lc);
    bus.req = 4'b1000;
    step();
    chk("rst/gnt_load", bus.gnt, 4'b1000);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst/gnt", bus.gnt, 4'b0);
    chk("rst/done", bus.done, 4'b0);
    chk("rst/fsm_load", bus.fsm_load, 1'b0);
    chk("rst/load_state", bus.fsm_load_state, 4'h0);
    chk("rst/result", bus.result_state, 4'h0);
    chk("rst/timeout_err", bus.timeout_err, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    mptr = 0;
    txn("post_rst", 4'b1100, 16'h5eb3, 1, 0, 4'h8, 2, 1'b0, 4'he, 4'h9, lc);

    for (int i = 0; i < 30; i++) begin
      r = 4'($urandom_range(1, 15));
      rs = 16'($urandom);
      da = $urandom_range(0, 16);
      key = 4'($urandom);
      dr = 0;
`ifndef DECODE_ARB_ABORT_EN
      if ($urandom_range(0, 3) == 0) dr = $urandom_range(1, 3);
`endif
      e_idx = pick(r, mptr);
      e_to = !(da >= 1 && da <= TIMEOUT);
      runs = e_to ? TIMEOUT : da;
      e_res = key ^ 4'(runs);
      txn($sformatf("rand%0d", i), r, rs, da, dr, key, e_idx, e_to,
          rs[e_idx*4 +: 4], e_res, lc);
    end

`ifdef DECODE_ARB_ABORT_EN
    prev_res = bus.result_state;
    bus.req = 4'b1000;
    bus.req_state = 16'h7000;
    step();
    chk("abort/gnt_load", bus.gnt, 4'b1000);
    step();
    bus.req = 4'b0000;
    bus.fsm_done = 1'b1;
    bus.fsm_state = 4'h3;
    step();
    chk("abort/gnt", bus.gnt, 4'b0);
    chk("abort/fsm_load", bus.fsm_load, 1'b1);
    chk("abort/load_state", bus.fsm_load_state, 4'hc);
    chk("abort/done", bus.done, 4'b0);
    chk("abort/timeout_err", bus.timeout_err, 1'b0);
    chk("abort/result", bus.result_state, prev_res);
    bus.fsm_done = 1'b0;
    step();
    chk("abort/load_idle", bus.fsm_load, 1'b0);
    chk("abort/done_idle", bus.done, 4'b0);
    mptr = 0;
    txn("abort_rr", 4'b1001, 16'h1234, 1, 0, 4'h2, 0, 1'b0, 4'h4, 4'h3, lc);
`else
    prev_res = 4'h0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
